bcd_time_keeper: RTL and testbench
==================================

// Module: bcd_time_keeper
// PURPOSE
//  Self-timed HH:MM:SS BCD time-of-day counter; successor to the fixed six-digit clock.
//  Adds on-chip second prescaler, cascaded carries, 12/24-hour build option, RUN/SET/HOLD modes,
//  validated parallel load with handshake, per-field set increments. Feeds display/alarm logic.
// PARAMETERS
//  TICK_DIV     50000000  clk cycles per second (>=2); prescaler counts 0..TICK_DIV-1
//  TWELVE_HOUR  0         0: hours 00-23; 1: hours 01-12 plus pm flag
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  mode         in   2   00 RUN, 01 SET, 10 HOLD, 11 treated as HOLD
//  load_valid   in   1   load request; time_in sampled when load_valid & load_ready
//  load_ready   out  1   1 in SET/HOLD, 0 in RUN (combinational from mode)
//  time_in      in   24  BCD {HH,MM,SS}; bit 24 n/a; pm_in used for 12h load
//  pm_in        in   1   pm value loaded in 12h build; ignored when TWELVE_HOUR=0
//  inc          in   1   SET-mode increment strobe, one step per cycle high
//  field_sel    in   2   00 seconds, 01 minutes, 10 hours, 11 none
//  time_bcd     out  24  registered BCD {H1,H0,M1,M0,S1,S0}
//  pm           out  1   registered; always 0 when TWELVE_HOUR=0
//  sec_tick     out  1   1-cycle pulse in the cycle time_bcd shows a RUN-mode advance
//  day_wrap     out  1   1-cycle pulse with the advance into 00:00:00 (24h) / 12:00:00 AM (12h)
//  load_err     out  1   1-cycle pulse on a rejected load
// BEHAVIOUR
//  Reset (async assert, sync release): time_bcd=24'h000000 (24h) / 24'h120000 (12h), pm=0,
//   prescaler=0, sec_tick=day_wrap=load_err=0.
//  Prescaler: counts only in RUN; tick when count==TICK_DIV-1, then count->0. In SET/HOLD held at 0,
//   so first RUN tick arrives TICK_DIV cycles after entering RUN. Time updates register the cycle after tick.
//  RUN advance: S0 0-9 carry S1 0-5 carry M0 0-9 carry M1 0-5 carry hours. 24h: 23->00 with day_wrap.
//   12h: 11->12 toggles pm; 12->01 no toggle; day_wrap when pm goes 1->0 (11:59:59PM->12:00:00AM).
//   sec_tick pulses on every advance, including the wrapping one.
//  SET: clock frozen; inc steps selected field by one with wrap inside field only, no carry
//   (sec 59->00, min 59->00, hr 23->00 or 12h 11->12 toggles pm, 12->01). No sec_tick/day_wrap.
//  HOLD: all state frozen; inc ignored.
//  Load: accepted when load_valid & load_ready. Legal = every nibble BCD<=9, S1/M1<=5, hours
//   00-23 (24h) or 01-12 (12h). Legal: time_bcd<=time_in, pm<=pm_in (12h) next edge. Illegal: state
//   unchanged, load_err pulses next cycle. load_valid in RUN ignored, no error.
//  Priority per cycle: reset > load > inc > tick. Load with inc same cycle: load wins, inc dropped.
//  Mode change RUN->SET/HOLD on the tick cycle: tick is dropped (mode sampled same edge).
//  No illegal state reachable except via reset mid-operation, which always restores reset values.
//  All outputs except load_ready are registered; no combinational path in->out besides load_ready.
// TESTING (TICK_DIV=4 unless stated)
//  1 Reset, RUN 40 cycles -> sec_tick every 4th cycle, time_bcd 000000->000001..000010 in 10 ticks.
//  2 HOLD, load 235958, RUN 8 cycles -> 235959 then 000000 with day_wrap=1 and sec_tick=1 same cycle.
//  3 TWELVE_HOUR=1: load 115959 pm=1, RUN one tick -> 120000 pm=0 day_wrap=1; load 125959 pm=0 -> 010000 pm=0.
//  4 SET, field_sel=01 from 005900, inc one cycle -> 000000 (hours untouched); field_sel=10 at 23 -> 00.
//  5 HOLD, load 246000 / 0A0000 / 006000 -> each rejected, load_err 1 cycle, time unchanged;
//    load in RUN -> load_ready=0, no change, no load_err; load+inc same cycle -> loaded value only.
//  6 RUN, assert rst_n=0 mid-prescale (count=2) -> outputs to reset values immediately, first
//    tick 4 cycles after release; switch to HOLD on tick cycle -> no advance.

Source files
------------

// File: rtl/bcd_time_keeper.sv
// HH:MM:SS BCD time-of-day counter with on-chip second prescaler, 12/24-hour build option,
// RUN/SET/HOLD modes, validated parallel load and per-field set increments.
module bcd_time_keeper #(
  parameter int TICK_DIV    = 50000000,
  parameter bit TWELVE_HOUR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] time_in,
  input  logic        pm_in,
  input  logic        inc,
  input  logic [1:0]  field_sel,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        load_err
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET      = 2'b01,
    MODE_HOLD     = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'b00,
    FIELD_MIN  = 2'b01,
    FIELD_HOUR = 2'b10,
    FIELD_NONE = 2'b11
  } field_t;

  localparam int            CW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);
  localparam logic [23:0]   RESET_TIME = TWELVE_HOUR ? 24'h120000 : 24'h000000;

  mode_t         mode_cur;
  field_t        field_cur;
  logic [CW-1:0] count;
  logic          in_run;
  logic          in_set;
  logic          tick;
  logic          load_fire;
  logic          load_ok;
  logic          set_fire;

  logic [8:0]    sec_step;
  logic [8:0]    min_step;
  logic [9:0]    hour_step;
  logic [23:0]   run_time;
  logic          run_pm;
  logic          run_wrap;
  logic [23:0]   set_time;
  logic          set_pm;

  // Minutes/seconds field step: returns {carry, next} with the 59 -> 00 roll.
  function automatic logic [8:0] step_sexa(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5)
        return {1'b1, 8'h00};
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Hour field step: returns {pm_toggle, wrap_24h, next}.
  function automatic logic [9:0] step_hour(input logic [7:0] v);
    logic [7:0] n;
    logic       toggle;
    logic       wrap;
    toggle = 1'b0;
    wrap   = 1'b0;
    if (v[3:0] == 4'd9)
      n = {v[7:4] + 4'd1, 4'd0};
    else
      n = {v[7:4], v[3:0] + 4'd1};
    if (TWELVE_HOUR) begin
      if (v == 8'h12)
        n = 8'h01;
      else if (v == 8'h11)
        toggle = 1'b1;
    end else if (v == 8'h23) begin
      n    = 8'h00;
      wrap = 1'b1;
    end
    return {toggle, wrap, n};
  endfunction

  function automatic logic load_legal(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[4*i +: 4] > 4'd9)
        ok = 1'b0;
    if (t[7:4] > 4'd5 || t[15:12] > 4'd5)
      ok = 1'b0;
    // Digits are already known to be BCD here, so a binary compare orders hours correctly.
    if (TWELVE_HOUR) begin
      if (t[23:16] == 8'h00 || t[23:16] > 8'h12)
        ok = 1'b0;
    end else if (t[23:16] > 8'h23) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  assign mode_cur   = mode_t'(mode);
  assign field_cur  = field_t'(field_sel);
  assign in_run     = (mode_cur == MODE_RUN);
  assign in_set     = (mode_cur == MODE_SET);
  assign load_ready = !in_run;
  assign load_fire  = load_valid && load_ready;
  assign load_ok    = load_legal(time_in);
  assign set_fire   = in_set && inc && (field_cur != FIELD_NONE);
  assign tick       = in_run && (count == LAST_COUNT);

  assign sec_step  = step_sexa(time_bcd[7:0]);
  assign min_step  = step_sexa(time_bcd[15:8]);
  assign hour_step = step_hour(time_bcd[23:16]);

  // RUN advance: cascaded carries seconds -> minutes -> hours.
  always_comb begin
    run_time = {time_bcd[23:8], sec_step[7:0]};
    run_pm   = pm;
    run_wrap = 1'b0;
    if (sec_step[8]) begin
      run_time[15:8] = min_step[7:0];
      if (min_step[8]) begin
        run_time[23:16] = hour_step[7:0];
        run_pm          = pm ^ hour_step[9];
        run_wrap        = TWELVE_HOUR ? (hour_step[9] & pm) : hour_step[8];
      end
    end
  end

  // SET increment: the selected field rolls on its own, nothing carries out of it.
  always_comb begin
    set_time = time_bcd;
    set_pm   = pm;
    case (field_cur)
      FIELD_SEC:  set_time[7:0]   = sec_step[7:0];
      FIELD_MIN:  set_time[15:8]  = min_step[7:0];
      FIELD_HOUR: begin
        set_time[23:16] = hour_step[7:0];
        set_pm          = pm ^ hour_step[9];
      end
      default:    set_time = time_bcd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_bcd <= RESET_TIME;
      pm       <= 1'b0;
      count    <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
      if (load_fire) begin
        if (load_ok) begin
          time_bcd <= time_in;
          pm       <= TWELVE_HOUR ? pm_in : 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (set_fire) begin
        time_bcd <= set_time;
        pm       <= set_pm;
      end else if (tick) begin
        time_bcd <= run_time;
        pm       <= run_pm;
        sec_tick <= 1'b1;
        day_wrap <= run_wrap;
      end
      // Held at zero outside RUN so the first tick lands a full period after entering RUN.
      if (!in_run)
        count <= '0;
      else if (tick)
        count <= '0;
      else
        count <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench: one 24h and one 12h instance share random stimulus; a seconds-of-day
// reference model predicts each cycle's outputs and a monitor process compares them.
module tb_bcd_time_keeper;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b10;
  logic        load_valid = 1'b0;
  logic [23:0] time_in = '0;
  logic        pm_in = 1'b0;
  logic        inc = 1'b0;
  logic [1:0]  field_sel = 2'b11;

  logic [23:0] time24, time12;
  logic        pm24, pm12, tick24, tick12, wrap24, wrap12, err24, err12, ready24, ready12;

  int total = 0;
  int bad   = 0;

  logic [27:0] q24[$];
  logic [27:0] q12[$];

  int t_m[2];
  int cnt_m[2];

  always #5 clk = ~clk;

  bcd_time_keeper #(.TICK_DIV(TD), .TWELVE_HOUR(1'b0)) dut24 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .load_valid(load_valid), .load_ready(ready24),
    .time_in(time_in), .pm_in(pm_in), .inc(inc), .field_sel(field_sel),
    .time_bcd(time24), .pm(pm24), .sec_tick(tick24), .day_wrap(wrap24), .load_err(err24)
  );

  bcd_time_keeper #(.TICK_DIV(TD), .TWELVE_HOUR(1'b1)) dut12 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .load_valid(load_valid), .load_ready(ready12),
    .time_in(time_in), .pm_in(pm_in), .inc(inc), .field_sel(field_sel),
    .time_bcd(time12), .pm(pm12), .sec_tick(tick12), .day_wrap(wrap12), .load_err(err12)
  );

  task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got time=%h pm=%b tick=%b wrap=%b err=%b, want time=%h pm=%b tick=%b wrap=%b err=%b",
               name, $time, act[27:4], act[3], act[2], act[1], act[0],
               exp[27:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [24:0] encode(input int t, input bit twelve);
    int   h, m, s;
    logic p;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    p = 1'b0;
    if (twelve) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p};
  endfunction

  // Returns seconds-of-day for a legal load, -1 for an illegal one.
  function automatic int decode_load(input logic [23:0] v, input logic p, input bit twelve);
    int d[6];
    int h, m, s;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > 9) return -1;
    end
    s = d[1] * 10 + d[0];
    m = d[3] * 10 + d[2];
    h = d[5] * 10 + d[4];
    if (s > 59 || m > 59) return -1;
    if (twelve) begin
      if (h < 1 || h > 12) return -1;
      h = (h % 12) + (p ? 12 : 0);
    end else if (h > 23) begin
      return -1;
    end
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic modelStep(input int k, input logic r, input logic [1:0] md, input logic lv,
                           input logic [23:0] ti, input logic pi, input logic ic,
                           input logic [1:0] fs, output logic [27:0] exp);
    logic tk, wr, er;
    int   v, h, m, s;
    tk = 1'b0; wr = 1'b0; er = 1'b0;
    if (!r) begin
      t_m[k]   = 0;
      cnt_m[k] = 0;
    end else begin
      if (md != 2'b00 && lv) begin
        v = decode_load(ti, pi, k == 1);
        if (v < 0) er = 1'b1;
        else t_m[k] = v;
      end else if (md == 2'b01 && ic && fs != 2'b11) begin
        h = t_m[k] / 3600; m = (t_m[k] / 60) % 60; s = t_m[k] % 60;
        case (fs)
          2'b00:   s = (s + 1) % 60;
          2'b01:   m = (m + 1) % 60;
          default: h = (h + 1) % 24;
        endcase
        t_m[k] = h * 3600 + m * 60 + s;
      end
      if (md == 2'b00) begin
        if (cnt_m[k] == TD - 1) begin
          cnt_m[k] = 0;
          t_m[k]   = (t_m[k] + 1) % 86400;
          tk       = 1'b1;
          wr       = (t_m[k] == 0);
        end else begin
          cnt_m[k]++;
        end
      end else begin
        cnt_m[k] = 0;
      end
    end
    exp = {encode(t_m[k], k == 1), tk, wr, er};
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] md, input logic lv,
                               input logic [23:0] ti, input logic pi, input logic ic,
                               input logic [1:0] fs);
    logic [27:0] e;
    @(negedge clk);
    rst_n = r; mode = md; load_valid = lv; time_in = ti; pm_in = pi; inc = ic; field_sel = fs;
    modelStep(0, r, md, lv, ti, pi, ic, fs, e);
    q24.push_back(e);
    modelStep(1, r, md, lv, ti, pi, ic, fs, e);
    q12.push_back(e);
    #1;
    checkOutput("ready24", {27'd0, ready24}, {27'd0, md != 2'b00});
    checkOutput("ready12", {27'd0, ready12}, {27'd0, md != 2'b00});
    if (!r) begin
      checkOutput("async_reset24", {time24, pm24, tick24, wrap24, err24}, {24'h000000, 4'b0000});
      checkOutput("async_reset12", {time12, pm12, tick12, wrap12, err12}, {24'h120000, 4'b0000});
    end
  endtask

  task automatic idle(input int n, input logic [1:0] md);
    repeat (n) applyStimulus(1'b1, md, 1'b0, 24'h0, 1'b0, 1'b0, 2'b11);
  endtask

  task automatic doLoad(input logic [1:0] md, input logic [23:0] ti, input logic pi);
    applyStimulus(1'b1, md, 1'b1, ti, pi, 1'b0, 2'b11);
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(1'b0, 2'b00, 1'b0, 24'h0, 1'b0, 1'b0, 2'b11);
  endtask

  function automatic logic [23:0] randomTime();
    int h, m, s;
    h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
    if ($urandom_range(0, 1) == 1) h = $urandom_range(1, 12);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Monitor: the DUT presents a fresh registered state every cycle, compared against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q24.size() > 0)
        checkOutput("dut24", {time24, pm24, tick24, wrap24, err24}, q24.pop_front());
      if (q12.size() > 0)
        checkOutput("dut12", {time12, pm12, tick12, wrap12, err12}, q12.pop_front());
    end
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [1:0]  md;
    logic [23:0] ti;
    int          pick;

    $display("[TB] directed sequences");
    doReset(2);
    idle(40, 2'b00);

    doLoad(2'b10, 24'h235958, 1'b0);
    idle(8, 2'b00);

    doLoad(2'b10, 24'h115959, 1'b1);
    idle(4, 2'b00);
    doLoad(2'b10, 24'h125959, 1'b0);
    idle(4, 2'b00);

    doLoad(2'b01, 24'h005900, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 24'h0, 1'b0, 1'b1, 2'b01);
    idle(2, 2'b01);
    doLoad(2'b01, 24'h230000, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 24'h0, 1'b0, 1'b1, 2'b10);
    applyStimulus(1'b1, 2'b01, 1'b0, 24'h0, 1'b0, 1'b1, 2'b10);
    applyStimulus(1'b1, 2'b01, 1'b0, 24'h0, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 2'b10, 1'b0, 24'h0, 1'b0, 1'b1, 2'b00);

    doLoad(2'b10, 24'h246000, 1'b0);
    doLoad(2'b10, 24'h0A0000, 1'b0);
    doLoad(2'b11, 24'h006000, 1'b0);
    idle(1, 2'b10);
    doLoad(2'b00, 24'h101010, 1'b0);
    idle(2, 2'b00);
    applyStimulus(1'b1, 2'b01, 1'b1, 24'h071530, 1'b1, 1'b1, 2'b00);
    idle(2, 2'b01);

    doReset(1);
    idle(2, 2'b00);
    doReset(2);
    idle(6, 2'b00);
    doReset(1);
    idle(3, 2'b00);
    idle(3, 2'b10);
    idle(5, 2'b00);

    $display("[TB] random sequences");
    for (int i = 0; i < 1500; i++) begin
      pick = $urandom_range(0, 99);
      md = (pick < 60) ? 2'b00 : (pick < 85) ? 2'b01 : 2'(pick % 2 + 2);
      ti = ($urandom_range(0, 3) == 0) ? 24'($urandom) : randomTime();
      applyStimulus($urandom_range(0, 99) != 0, md, $urandom_range(0, 99) < 15, ti,
                    1'($urandom), 1'($urandom), 2'($urandom));
    end
    idle(2, 2'b10);

    repeat (4) @(posedge clk);
    #2;
    total++;
    if (q24.size() != 0 || q12.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d/%0d pending, want 0/0", q24.size(), q12.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
